// File: rtl/irda_dma_master.sv
// WISHBONE DMA initiator for the IrDA core: one 32-bit word per core request,
// memory -> TX FIFO and RX FIFO -> memory, with RX given priority.
module irda_dma_master #(
  parameter logic [31:0] TXF_ADR = 32'h9000_0000,
  parameter logic [31:0] RXF_ADR = 32'h9000_0000,
  parameter int          LEN_W   = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [31:0]      tx_base_i,
  input  logic [LEN_W-1:0] tx_len_i,
  input  logic             tx_start_i,
  input  logic [31:0]      rx_base_i,
  input  logic [LEN_W-1:0] rx_len_i,
  input  logic             rx_start_i,
  input  logic             dma_req_t_i,
  output logic             dma_ack_t_o,
  input  logic             dma_req_r_i,
  output logic             dma_ack_r_o,
  output logic [31:0]      m_adr_o,
  output logic [31:0]      m_dat_o,
  input  logic [31:0]      m_dat_i,
  output logic             m_we_o,
  output logic             m_stb_o,
  output logic             m_cyc_o,
  input  logic             m_ack_i,
  input  logic             m_err_i,
  output logic             tx_busy_o,
  output logic             rx_busy_o,
  output logic             tx_done_o,
  output logic             rx_done_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_RD, S_TX_WR, S_RX_RD, S_RX_WR, S_ACK, S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic             sep_q, sep_d;
  logic             rx_sel_q, rx_sel_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      tx_adr_q, tx_adr_d, rx_adr_q, rx_adr_d;
  logic [LEN_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic             tx_zdone_q, tx_zdone_d, rx_zdone_q, rx_zdone_d;
  logic             err_q, err_d;
  logic             tx_busy, rx_busy, bus_err;
  logic             tx_done_ack, rx_done_ack;

  assign tx_busy = (tx_cnt_q != '0);
  assign rx_busy = (rx_cnt_q != '0);

  always_comb begin
    state_d     = state_q;
    sep_d       = sep_q;
    rx_sel_d    = rx_sel_q;
    data_d      = data_q;
    tx_adr_d    = tx_adr_q;
    rx_adr_d    = rx_adr_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    tx_zdone_d  = 1'b0;
    rx_zdone_d  = 1'b0;
    err_d       = 1'b0;
    bus_err     = 1'b0;
    m_stb_o     = 1'b0;
    m_adr_o     = '0;
    m_dat_o     = '0;
    m_we_o      = 1'b0;
    dma_ack_t_o = 1'b0;
    dma_ack_r_o = 1'b0;
    tx_done_ack = 1'b0;
    rx_done_ack = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_busy && dma_req_r_i) begin
          state_d  = S_RX_RD;
          rx_sel_d = 1'b1;
        end else if (tx_busy && dma_req_t_i) begin
          state_d  = S_TX_RD;
          rx_sel_d = 1'b0;
        end
      end
      S_TX_RD, S_RX_RD: begin
        m_stb_o = 1'b1;
        m_adr_o = (state_q == S_TX_RD) ? tx_adr_q : RXF_ADR;
        if (m_err_i) begin
          bus_err = 1'b1;
        end else if (m_ack_i) begin
          data_d  = m_dat_i;
          sep_d   = 1'b1;
          state_d = (state_q == S_TX_RD) ? S_TX_WR : S_RX_WR;
        end
      end
      S_TX_WR, S_RX_WR: begin
        // First cycle after the read is a dead bus cycle between phases.
        if (sep_q) begin
          sep_d = 1'b0;
        end else begin
          m_stb_o = 1'b1;
          m_we_o  = 1'b1;
          m_dat_o = data_q;
          m_adr_o = (state_q == S_TX_WR) ? TXF_ADR : rx_adr_q;
          if (m_err_i) begin
            bus_err = 1'b1;
          end else if (m_ack_i) begin
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        state_d = S_GAP;
        if (rx_sel_q) begin
          dma_ack_r_o = 1'b1;
          rx_adr_d    = rx_adr_q + 32'd4;
          rx_cnt_d    = rx_cnt_q - LEN_W'(1);
          rx_done_ack = (rx_cnt_q == LEN_W'(1));
        end else begin
          dma_ack_t_o = 1'b1;
          tx_adr_d    = tx_adr_q + 32'd4;
          tx_cnt_d    = tx_cnt_q - LEN_W'(1);
          tx_done_ack = (tx_cnt_q == LEN_W'(1));
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (bus_err) begin
      err_d   = 1'b1;
      state_d = S_GAP;
      sep_d   = 1'b0;
      if (rx_sel_q) rx_cnt_d = '0;
      else          tx_cnt_d = '0;
    end

    // A start only touches an idle channel, so it never collides with the bus updates above.
    if (tx_start_i && !tx_busy) begin
      if (tx_len_i == '0) begin
        tx_zdone_d = 1'b1;
      end else begin
        tx_adr_d = tx_base_i;
        tx_cnt_d = tx_len_i;
      end
    end
    if (rx_start_i && !rx_busy) begin
      if (rx_len_i == '0) begin
        rx_zdone_d = 1'b1;
      end else begin
        rx_adr_d = rx_base_i;
        rx_cnt_d = rx_len_i;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      sep_q      <= 1'b0;
      rx_sel_q   <= 1'b0;
      data_q     <= '0;
      tx_adr_q   <= '0;
      rx_adr_q   <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      tx_zdone_q <= 1'b0;
      rx_zdone_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sep_q      <= sep_d;
      rx_sel_q   <= rx_sel_d;
      data_q     <= data_d;
      tx_adr_q   <= tx_adr_d;
      rx_adr_q   <= rx_adr_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_zdone_q <= tx_zdone_d;
      rx_zdone_q <= rx_zdone_d;
      err_q      <= err_d;
    end
  end

  assign m_cyc_o   = m_stb_o;
  assign tx_busy_o = tx_busy;
  assign rx_busy_o = rx_busy;
  assign tx_done_o = tx_zdone_q | tx_done_ack;
  assign rx_done_o = rx_zdone_q | rx_done_ack;
  assign err_o     = err_q;

endmodule

// File: tb/tb_irda_dma_master.sv
// Directed + randomized bench for irda_dma_master: a WISHBONE slave with memory,
// FIFO endpoints, wait states and error injection, checked against a transfer-level model.
module tb_irda_dma_master;
  localparam logic [31:0] TXF = 32'h9000_0000;
  localparam logic [31:0] RXF = 32'h9000_0000;
  localparam int LEN_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] tx_base = '0, rx_base = '0;
  logic [LEN_W-1:0] tx_len = '0, rx_len = '0;
  logic tx_start = 1'b0, rx_start = 1'b0, req_t = 1'b0, req_r = 1'b0;
  logic ack_t, ack_r, m_we, m_stb, m_cyc, tx_busy, rx_busy, tx_done, rx_done, err;
  logic [31:0] m_adr, m_dat_o;
  logic [31:0] s_dat = '0;
  logic s_ack = 1'b0, s_err = 1'b0;

  irda_dma_master #(.TXF_ADR(TXF), .RXF_ADR(RXF), .LEN_W(LEN_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .tx_base_i(tx_base), .tx_len_i(tx_len), .tx_start_i(tx_start),
    .rx_base_i(rx_base), .rx_len_i(rx_len), .rx_start_i(rx_start),
    .dma_req_t_i(req_t), .dma_ack_t_o(ack_t), .dma_req_r_i(req_r), .dma_ack_r_o(ack_r),
    .m_adr_o(m_adr), .m_dat_o(m_dat_o), .m_dat_i(s_dat), .m_we_o(m_we),
    .m_stb_o(m_stb), .m_cyc_o(m_cyc), .m_ack_i(s_ack), .m_err_i(s_err),
    .tx_busy_o(tx_busy), .rx_busy_o(rx_busy), .tx_done_o(tx_done), .rx_done_o(rx_done),
    .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_t;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] rxfifo [$];
  logic [31:0] txfifo [$];
  bus_t        log_q [$];
  bus_t        exp_q [$];
  logic [31:0] xdata [8];

  int wait_n = 0;
  int wait_ctr = 0;
  bit err_en = 1'b0;
  logic [31:0] err_adr = '0;
  int cyc = 0;

  int vectors = 0;
  int miscompares = 0;

  // Slave: answers one cycle after the strobe is seen (plus wait_n), ack or err for one cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      s_ack <= 1'b0; s_err <= 1'b0; wait_ctr <= 0;
    end else if (m_stb && !s_ack && !s_err) begin
      if (wait_ctr < wait_n) begin
        wait_ctr <= wait_ctr + 1;
      end else begin
        wait_ctr <= 0;
        if (err_en && !m_we && m_adr == err_adr) begin
          s_err <= 1'b1;
        end else begin
          s_ack <= 1'b1;
          if (m_we) begin
            if (m_adr == TXF) txfifo.push_back(m_dat_o);
            else mem[m_adr] = m_dat_o;
            log_q.push_back('{1'b1, m_adr, m_dat_o});
          end else begin
            logic [31:0] v;
            if (m_adr == RXF) v = (rxfifo.size() > 0) ? rxfifo.pop_front() : 32'h0;
            else v = mem.exists(m_adr) ? mem[m_adr] : 32'h0;
            s_dat <= v;
            log_q.push_back('{1'b0, m_adr, v});
          end
        end
      end
    end else begin
      s_ack <= 1'b0; s_err <= 1'b0;
    end
  end

  int ack_t_cnt = 0, ack_r_cnt = 0, tx_done_cnt = 0, rx_done_cnt = 0, err_cnt = 0;
  int ack_t_cyc = 0, ack_r_cyc = 0, cyc_bad = 0, stab_bad = 0;
  logic tx_done_ack = 1'b0, rx_done_ack = 1'b0, prev_stb = 1'b0;
  logic [64:0] prev_bus = '0;

  always @(negedge clk) begin
    if (ack_t) begin ack_t_cnt <= ack_t_cnt + 1; ack_t_cyc <= cyc; end
    if (ack_r) begin ack_r_cnt <= ack_r_cnt + 1; ack_r_cyc <= cyc; end
    if (tx_done) begin tx_done_cnt <= tx_done_cnt + 1; tx_done_ack <= ack_t; end
    if (rx_done) begin rx_done_cnt <= rx_done_cnt + 1; rx_done_ack <= ack_r; end
    if (err) err_cnt <= err_cnt + 1;
    if (m_cyc !== m_stb) cyc_bad <= cyc_bad + 1;
    if (prev_stb && m_stb && ({m_adr, m_we, m_dat_o} !== prev_bus)) stab_bad <= stab_bad + 1;
    prev_stb <= m_stb;
    prev_bus <= {m_adr, m_we, m_dat_o};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {22'd0, m_stb, m_cyc, m_we, ack_t, ack_r, tx_busy, rx_busy,
                          tx_done, rx_done, err}, 32'd0);
    check({tag, "_adr"}, m_adr, 32'd0);
    check({tag, "_dat"}, m_dat_o, 32'd0);
  endtask

  // Reference: each word is a read from the source then a write of that value to the sink.
  task automatic fill_model(input bit rx, input logic [31:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      logic [31:0] a;
      a = base + 32'(4 * i);
      if (rx) begin
        rxfifo.push_back(xdata[i]);
        exp_q.push_back('{1'b0, RXF, xdata[i]});
        exp_q.push_back('{1'b1, a, xdata[i]});
      end else begin
        mem[a] = xdata[i];
        exp_q.push_back('{1'b0, a, xdata[i]});
        exp_q.push_back('{1'b1, TXF, xdata[i]});
      end
    end
  endtask

  task automatic arm(input bit rx, input logic [31:0] base, input int len);
    @(negedge clk);
    if (rx) begin rx_base = base; rx_len = LEN_W'(len); rx_start = 1'b1; end
    else    begin tx_base = base; tx_len = LEN_W'(len); tx_start = 1'b1; end
    @(negedge clk);
    rx_start = 1'b0; tx_start = 1'b0;
  endtask

  task automatic wait_done(input bit rx, input int target, input string tag);
    int n = 0;
    while ((rx ? rx_done_cnt : tx_done_cnt) < target && n < 2000) begin
      @(negedge clk); n++;
    end
    check({tag, "_timeout"}, 32'((rx ? rx_done_cnt : tx_done_cnt) >= target), 32'd1);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_nlog"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_we%0d", tag, i), 32'(log_q[i].we), 32'(exp_q[i].we));
      check($sformatf("%s_adr%0d", tag, i), log_q[i].adr, exp_q[i].adr);
      check($sformatf("%s_dat%0d", tag, i), log_q[i].dat, exp_q[i].dat);
    end
  endtask

  // Raise the request, hold it until done, then compare bus traffic and handshakes.
  task automatic finish_xfer(input bit rx, input int len, input string tag);
    int a0, d0, n;
    a0 = rx ? ack_r_cnt : ack_t_cnt;
    d0 = rx ? rx_done_cnt : tx_done_cnt;
    @(negedge clk);
    if (rx) req_r = 1'b1; else req_t = 1'b1;
    if (wait_n == 0) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!(rx ? ack_r : ack_t) && n < 50);
      check({tag, "_latency"}, n, 32'd6);
    end
    wait_done(rx, d0 + 1, tag);
    @(negedge clk);
    req_r = 1'b0; req_t = 1'b0;
    repeat (3) @(negedge clk);
    check_log(tag);
    check({tag, "_acks"}, (rx ? ack_r_cnt : ack_t_cnt) - a0, len);
    check({tag, "_dones"}, (rx ? rx_done_cnt : tx_done_cnt) - d0, 32'd1);
    check({tag, "_done_on_ack"}, 32'(rx ? rx_done_ack : tx_done_ack), 32'd1);
    check({tag, "_busy"}, 32'(rx ? rx_busy : tx_busy), 32'd0);
    $display("xfer %s: %s len=%0d waits=%0d words_logged=%0d", tag, rx ? "rx" : "tx",
             len, wait_n, log_q.size());
  endtask

  task automatic run_xfer(input bit rx, input logic [31:0] base, input int len, input string tag);
    log_q.delete(); exp_q.delete();
    fill_model(rx, base, len);
    arm(rx, base, len);
    check({tag, "_armed"}, 32'(rx ? rx_busy : tx_busy), 32'd1);
    finish_xfer(rx, len, tag);
  endtask

  initial begin
    int a0, d0, e0, n;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    @(negedge clk) rst = 1'b0;

    // TX three words from 0x100
    xdata[0] = 32'hA0A0_0001; xdata[1] = 32'hB0B0_0002; xdata[2] = 32'hC0C0_0003;
    run_xfer(1'b0, 32'h100, 3, "tx3");

    // RX two words into 0x200
    xdata[0] = 32'hDEAD_BEEF; xdata[1] = 32'h1234_5678;
    run_xfer(1'b1, 32'h200, 2, "rx2");
    check("rx2_mem0", mem[32'h200], 32'hDEAD_BEEF);
    check("rx2_mem1", mem[32'h204], 32'h1234_5678);

    // Address wrap at the top of the space
    xdata[0] = 32'h1111_2222; xdata[1] = 32'h3333_4444;
    run_xfer(1'b0, 32'hFFFF_FFFC, 2, "wrap");

    // Simultaneous requests: RX served first, TX follows after GAP+IDLE
    log_q.delete(); exp_q.delete();
    xdata[0] = 32'h5555_AAAA; fill_model(1'b1, 32'h400, 1);
    xdata[0] = 32'h6666_BBBB; fill_model(1'b0, 32'h300, 1);
    arm(1'b1, 32'h400, 1);
    arm(1'b0, 32'h300, 1);
    @(negedge clk); req_r = 1'b1; req_t = 1'b1;
    wait_done(1'b0, tx_done_cnt + 1, "simul");
    @(negedge clk); req_r = 1'b0; req_t = 1'b0;
    repeat (2) @(negedge clk);
    check_log("simul");
    check("simul_order", ack_t_cyc - ack_r_cyc, 32'd8);
    $display("xfer simul: rx ack at %0d, tx ack at %0d", ack_r_cyc, ack_t_cyc);

    // Bus error on the second TX memory read of four
    log_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) xdata[i] = $urandom;
    fill_model(1'b0, 32'h500, 1);
    mem[32'h504] = xdata[1]; mem[32'h508] = xdata[2]; mem[32'h50C] = xdata[3];
    err_en = 1'b1; err_adr = 32'h504;
    a0 = ack_t_cnt; d0 = tx_done_cnt; e0 = err_cnt;
    arm(1'b0, 32'h500, 4);
    @(negedge clk); req_t = 1'b1;
    n = 0;
    while (err_cnt == e0 && n < 200) begin @(negedge clk); n++; end
    check("berr_seen", 32'(err_cnt != e0), 32'd1);
    repeat (10) @(negedge clk);
    req_t = 1'b0; err_en = 1'b0;
    repeat (2) @(negedge clk);
    check("berr_pulses", err_cnt - e0, 32'd1);
    check("berr_acks", ack_t_cnt - a0, 32'd1);
    check("berr_dones", tx_done_cnt - d0, 32'd0);
    check("berr_busy", 32'(tx_busy), 32'd0);
    check_log("berr");
    $display("xfer berr: tx len=4 aborted, words_logged=%0d", log_q.size());

    // Zero-length start: done next cycle, no bus activity
    @(negedge clk); tx_len = '0; tx_base = 32'h900; tx_start = 1'b1;
    @(posedge clk); #1;
    check("zlen_done", 32'(tx_done), 32'd1);
    check("zlen_stb", 32'(m_stb), 32'd0);
    check("zlen_busy", 32'(tx_busy), 32'd0);
    @(negedge clk); tx_start = 1'b0;
    @(posedge clk); #1;
    check("zlen_done_off", 32'(tx_done), 32'd0);
    $display("xfer zlen: tx len=0 done pulse only");

    // Start while busy is ignored: five words from 0x600 still run
    log_q.delete(); exp_q.delete();
    for (int i = 0; i < 5; i++) xdata[i] = $urandom;
    fill_model(1'b0, 32'h600, 5);
    arm(1'b0, 32'h600, 5);
    arm(1'b0, 32'h800, 2);
    check("restart_busy", 32'(tx_busy), 32'd1);
    finish_xfer(1'b0, 5, "restart");

    // Randomized transfers with random wait states
    for (int k = 0; k < 8; k++) begin
      bit rx;
      int len;
      logic [31:0] base;
      rx = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 4);
      base = 32'h0001_0000 + (32'($urandom_range(0, 4095)) << 2);
      wait_n = $urandom_range(0, 2);
      for (int i = 0; i < len; i++) xdata[i] = $urandom;
      run_xfer(rx, base, len, $sformatf("rnd%0d", k));
    end

    // Reset during a wait-stated TX write
    wait_n = 5;
    log_q.delete(); exp_q.delete();
    xdata[0] = 32'h7777_0000; xdata[1] = 32'h7777_0001;
    fill_model(1'b0, 32'h700, 2);
    arm(1'b0, 32'h700, 2);
    @(negedge clk); req_t = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(m_stb && m_we) && n < 100);
    check("rstx_in_wr", 32'(m_stb && m_we), 32'd1);
    @(negedge clk); rst = 1'b1; a0 = ack_t_cnt;
    @(posedge clk); #1;
    check_idle("rstx");
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    check("rstx_no_ack", ack_t_cnt - a0, 32'd0);
    check("rstx_busy", 32'(tx_busy), 32'd0);
    req_t = 1'b0; wait_n = 0;
    $display("xfer rstx: tx aborted by reset during write");

    check("cyc_eq_stb", cyc_bad, 32'd0);
    check("bus_stable", stab_bad, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/irda_dma_master.md
Name: irda_dma_master

Overview:
- DMA initiator for the IrDA core's DMA handshake (dma_req_t/dma_ack_t, dma_req_r/dma_ack_r).
- Acts as a WISHBONE master on a shared bus: moves one 32-bit word per core request.
- TX direction: system memory -> IrDA TX FIFO register. RX direction: IrDA RX FIFO register -> system memory.
- Software programs base address and word count per channel, then pulses start. Done and error are reported as one-cycle pulses.

Parameters:
- TXF_ADR, 32'h9000_0000, bus address of the IrDA TX FIFO data register (written).
- RXF_ADR, 32'h9000_0000, bus address of the IrDA RX FIFO data register (read).
- LEN_W, 16, width of the word-count registers.

Ports:
- wb_clk_i  in  1  single system clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- tx_base_i  in  32  TX source memory address, word aligned.
- tx_len_i  in  LEN_W  TX word count.
- tx_start_i  in  1  pulse; loads tx_base_i and tx_len_i, arms the TX channel.
- rx_base_i  in  32  RX destination memory address, word aligned.
- rx_len_i  in  LEN_W  RX word count.
- rx_start_i  in  1  pulse; arms the RX channel.
- dma_req_t_i  in  1  core requests a TX FIFO fill (level).
- dma_ack_t_o  out  1  one-cycle acknowledge of one TX word.
- dma_req_r_i  in  1  core requests an RX FIFO drain (level).
- dma_ack_r_o  out  1  one-cycle acknowledge of one RX word.
- m_adr_o  out  32  master address.
- m_dat_o  out  32  master write data.
- m_dat_i  in  32  master read data.
- m_we_o  out  1  write enable.
- m_stb_o  out  1  strobe.
- m_cyc_o  out  1  cycle; always equal to m_stb_o.
- m_ack_i  in  1  slave acknowledge.
- m_err_i  in  1  slave error.
- tx_busy_o  out  1  TX channel armed, words remaining.
- rx_busy_o  out  1  RX channel armed.
- tx_done_o  out  1  pulse on the last TX word.
- rx_done_o  out  1  pulse on the last RX word.
- err_o  out  1  pulse on bus error.

Behaviour:
- Reset: every output is 0. FSM goes to IDLE. Both channels are disarmed and their counters and address registers cleared.
- Reset asserted mid-cycle drops m_cyc_o/m_stb_o on the next edge. No ack is issued for that word.
- Per channel:
  - Registers: addr (32) and remaining count (LEN_W).
  - busy = (remaining != 0).
  - start while busy is ignored.
  - start with length 0 does not arm the channel and pulses done on the next cycle.
- FSM states: IDLE, TX_RD, TX_WR, RX_RD, RX_WR, ACK, GAP.
- IDLE arbitration: if rx_busy & dma_req_r_i go to RX_RD; else if tx_busy & dma_req_t_i go to TX_RD. RX has fixed priority to avoid receiver overrun.
- TX_RD: m_adr_o = tx addr, m_we_o = 0, stb/cyc = 1. Hold until m_ack_i, latch m_dat_i into the data register, go to TX_WR.
- TX_WR: m_adr_o = TXF_ADR, m_we_o = 1, m_dat_o = data register. On m_ack_i go to ACK.
- RX_RD: m_adr_o = RXF_ADR, read, latch on ack, go to RX_WR.
- RX_WR: m_adr_o = rx addr, write the data register, on ack go to ACK.
- stb/cyc are deasserted for at least one cycle between the read and write phases: one idle cycle is inserted on each phase change.
- All address, data and we outputs are stable while stb is high.
- ACK state (one cycle):
  - Pulse dma_ack_t_o or dma_ack_r_o for the served channel.
  - addr += 4 (32-bit wrap permitted, no carry out).
  - remaining -= 1.
  - If remaining reaches 0, pulse that channel's done in the same cycle.
- GAP: one cycle with no request sampling, so the core can drop its level request. Then return to IDLE.
- m_err_i in any bus state:
  - Terminate the cycle (stb/cyc low next edge).
  - Pulse err_o.
  - Disarm the offending channel (remaining = 0, no done pulse, no dma ack).
  - Go to GAP.
- m_ack_i and m_err_i together: error wins.
- Requests arriving for a disarmed channel are ignored; the ack stays 0.
- Latency with zero-wait slaves, from request sampled in IDLE to the ack pulse is 6 cycles:
  - read: 1 cycle, plus 1 cycle for the ack;
  - gap: 1 cycle;
  - write: 1 cycle, plus 1 cycle for the ack;
  - ACK: 1 cycle.
- A start pulse for one channel is accepted in any state; the other channel's transfer is unaffected.

Test Plan:
- TX, 3 words:
  - Stimulus: base 0x100, len 3, dma_req_t_i held high, memory holds A,B,C.
  - Expect: reads at 0x100/0x104/0x108; writes A,B,C to TXF_ADR; three dma_ack_t_o pulses; tx_done_o on the third ack; tx_busy_o then 0.
- RX, 2 words:
  - Stimulus: base 0x200, len 2, RX FIFO returns 0xDEADBEEF then 0x12345678.
  - Expect: memory writes at 0x200 and 0x204 with those values; rx_done_o on the second ack.
- Simultaneous requests:
  - Stimulus: both channels armed, dma_req_r_i and dma_req_t_i rise in the same cycle.
  - Expect: the RX word is served first, then the TX word after GAP.
- Bus error:
  - Stimulus: m_err_i on the TX memory read (word 2 of 4).
  - Expect: err_o pulse; no dma_ack_t_o for that word; tx_busy_o = 0; no tx_done_o.
- Zero length and re-start:
  - Stimulus: tx_len 0 start, then a start while busy.
  - Expect: for the zero-length start, tx_done_o one cycle later and no bus cycle.
  - Expect: the start while busy leaves the count unchanged.
- Reset mid-transfer:
  - Stimulus: wb_rst_i asserted during TX_WR with a wait-stated slave.
  - Expect: m_cyc_o = 0 on the next edge, all outputs 0, no ack.
